// File: rtl/audio_out_pkg.sv
// Shared register map, bit positions and status word layout for audio_out_driver.
package audio_out_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_CTRL     = 2'd2;
  localparam logic [1:0] ADDR_UNDERRUN = 2'd3;

  localparam int STAT_EMPTY    = 8;
  localparam int STAT_FULL     = 9;
  localparam int STAT_OVERFLOW = 10;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_FLUSH  = 1;

  typedef struct packed {
    logic [20:0] rsvd_hi;
    logic        overflow;
    logic        full;
    logic        empty;
    logic [1:0]  rsvd_lo;
    logic [5:0]  count;
  } status_t;

endpackage

// File: rtl/audio_out_fifo.sv
// First-word-fall-through FIFO; head is valid whenever empty is low.
module audio_out_fifo
  import audio_out_pkg::*;
#(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     empty,
  output logic                     full,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rd_ptr];
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & ~flush & (~full | pop_ok);

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_next = count + (AW+1)'(1);
        2'b01:   count_next = count - (AW+1)'(1);
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count <= count_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) begin
          mem[wr_ptr] <= din;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/audio_out_driver.sv
// Avalon-MM sample writes buffered into an Avalon-ST source with refill irq.
// Optional underrun counter at address 3 enabled by AUDIO_OUT_UNDERRUN_CNT_EN.
module audio_out_driver
  import audio_out_pkg::*;
#(
  parameter int DATA_SIZE  = 28,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WM     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chipselect,
  input  logic [1:0]           address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          writedata,
  output logic [31:0]          read_data,
  output logic                 source_valid,
  output logic [DATA_SIZE-1:0] source_data,
  input  logic                 source_ready,
  output logic                 irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          empty;
  logic          full;
  logic          irq_en;
  logic          irq_en_next;
  logic          overflow;
  logic          data_wr;
  logic          stat_wr;
  logic          ctrl_wr;
  logic          flush;
  logic          mm_rd;
  logic          overflow_set;
  status_t       status;
  logic [31:0]   underrun_word;

  assign data_wr = chipselect & write & (address == ADDR_DATA);
  assign stat_wr = chipselect & write & (address == ADDR_STATUS);
  assign ctrl_wr = chipselect & write & (address == ADDR_CTRL);
  assign mm_rd   = chipselect & read;
  assign flush   = ctrl_wr & writedata[CTRL_FLUSH];

  audio_out_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (data_wr),
    .din        (writedata[DATA_SIZE-1:0]),
    .pop        (source_ready),
    .flush      (flush),
    .count      (count),
    .count_next (count_next),
    .empty      (empty),
    .full       (full),
    .head       (source_data)
  );

  assign source_valid = ~empty;
  // Dropped only when nothing leaves to make room this cycle.
  assign overflow_set = data_wr & full & ~(source_ready & ~empty) & ~flush;
  assign irq_en_next  = ctrl_wr ? writedata[CTRL_IRQ_EN] : irq_en;

  always_comb begin
    status          = '0;
    status.count    = 6'(count);
    status.empty    = empty;
    status.full     = full;
    status.overflow = overflow;
  end

`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
  logic [15:0] underrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun <= '0;
    end else if (chipselect & write & (address == ADDR_UNDERRUN)) begin
      underrun <= '0;
    end else if (source_ready & empty & (underrun != 16'hFFFF)) begin
      underrun <= underrun + 16'd1;
    end
  end

  assign underrun_word = {16'd0, underrun};
`else
  assign underrun_word = 32'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
      irq_en    <= 1'b0;
      irq       <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      irq_en <= irq_en_next;
      irq    <= irq_en_next & (count_next <= CW'(LOW_WM));
      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (stat_wr & writedata[STAT_OVERFLOW]) begin
        overflow <= 1'b0;
      end
      if (mm_rd) begin
        case (address)
          ADDR_STATUS:   read_data <= status;
          ADDR_CTRL:     read_data <= {31'd0, irq_en};
          ADDR_UNDERRUN: read_data <= underrun_word;
          default:       read_data <= 32'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_out_driver.sv
// Directed bench for audio_out_driver: queue-based reference model checked every cycle.
module tb_audio_out_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        chipselect = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] read_data;
  logic        source_valid;
  logic [27:0] source_data;
  logic        source_ready = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  audio_out_driver dut (
    .clk          (clk),
    .rst          (rst),
    .chipselect   (chipselect),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .read_data    (read_data),
    .source_valid (source_valid),
    .source_data  (source_data),
    .source_ready (source_ready),
    .irq          (irq)
  );

  always #10 clk = ~clk;

  // Reference model: sample queue plus register-level state.
  logic [27:0] exp_q[$];
  logic        m_ovf = 1'b0;
  logic        m_irq_en = 1'b0;
  logic        m_irq = 1'b0;
  logic [31:0] m_rd = 32'd0;
  int          m_under = 0;

  function automatic logic [31:0] model_reg(input logic [1:0] a);
    int n;
    n = exp_q.size();
    case (a)
      2'd1: return (32'(m_ovf) << 10) | (32'(n == 16) << 9) | (32'(n == 0) << 8) | 32'(n);
      2'd2: return 32'(m_irq_en);
`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
      2'd3: return 32'(m_under);
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_ovf = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0; m_rd = 32'd0; m_under = 0;
    end else begin
      int  pre_n;
      bit  do_pop, wr, fl;
      pre_n  = exp_q.size();
      do_pop = source_ready && (pre_n > 0);
      wr     = chipselect && write;
      fl     = wr && (address == 2'd2) && writedata[1];
      if (chipselect && read) m_rd = model_reg(address);
      if (wr && address == 2'd3) m_under = 0;
      else if (source_ready && pre_n == 0 && m_under < 65535) m_under++;
      if (fl) begin
        exp_q.delete();
      end else begin
        if (do_pop) void'(exp_q.pop_front());
        if (wr && address == 2'd0) begin
          if (pre_n < 16 || do_pop) exp_q.push_back(writedata[27:0]);
          else m_ovf = 1'b1;
        end
      end
      if (wr && address == 2'd1 && writedata[10]) m_ovf = 1'b0;
      if (wr && address == 2'd2) m_irq_en = writedata[0];
      m_irq = m_irq_en && (exp_q.size() <= 4);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_valid", 32'(source_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("model_data", 32'(source_data), 32'(exp_q[0]));
      chk("model_irq", 32'(irq), 32'(m_irq));
      chk("model_read_data", read_data, m_rd);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
    end
  endtask

  task automatic mm_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
  endtask

  task automatic mm_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = read_data;
  endtask

  logic [31:0] rv;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);
    chk("reset_valid", 32'(source_valid), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    mm_read(1, rv); chk("reset_status", rv, 32'h0000_0100);

    // Single sample held while ready is low, then consumed.
    mm_write(0, 32'hF123_4567);
    idle(1);
    chk("single_valid", 32'(source_valid), 32'd1);
    chk("single_data", 32'(source_data), 32'h0123_4567);
    idle(2);
    chk("single_hold", 32'(source_data), 32'h0123_4567);
    source_ready = 1'b1;
    idle(1);
    source_ready = 1'b0;
    chk("single_drained", 32'(source_valid), 32'd0);

    // Overflow: 17th sample dropped, then in-order drain.
    for (int i = 1; i <= 17; i++) mm_write(0, 32'(i));
    idle(1);
    mm_read(1, rv); chk("full_status", rv, 32'h0000_0610);
    source_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      chk("drain_order", 32'(source_data), 32'(k));
      idle(1);
    end
    source_ready = 1'b0;
    chk("drain_no_17", 32'(source_valid), 32'd0);
    mm_write(1, 32'h400);
    idle(1);
    mm_read(1, rv); chk("ovf_cleared", rv, 32'h0000_0100);

    // Full with simultaneous push and pop: no overflow, stays full.
    for (int i = 0; i < 16; i++) mm_write(0, 32'(100 + i));
    mm_write(0, 32'd200);
    source_ready = 1'b1;
    idle(1);
    source_ready = 1'b0;
    mm_read(1, rv); chk("full_push_pop", rv, 32'h0000_0210);
    source_ready = 1'b1;
    idle(18);
    // Empty with push and ready together: sample appears, then leaves.
    mm_write(0, 32'd77);
    idle(1);
    chk("empty_push_pop", 32'(source_data), 32'd77);
    idle(1);
    source_ready = 1'b0;
    chk("empty_push_gone", 32'(source_valid), 32'd0);

    // irq watermark behaviour.
    mm_write(2, 32'h1);
    idle(1);
    chk("irq_empty", 32'(irq), 32'd1);
    for (int i = 0; i < 4; i++) mm_write(0, 32'(10 + i));
    idle(1);
    chk("irq_at_4", 32'(irq), 32'd1);
    mm_write(0, 32'd14);
    idle(1);
    chk("irq_at_5", 32'(irq), 32'd0);
    source_ready = 1'b1;
    idle(1);
    source_ready = 1'b0;
    chk("irq_drain_4", 32'(irq), 32'd1);
    mm_write(2, 32'h0);
    idle(1);
    chk("irq_disabled", 32'(irq), 32'd0);
    source_ready = 1'b1;
    idle(5);
    source_ready = 1'b0;

    // Flush.
    for (int i = 0; i < 8; i++) mm_write(0, 32'(300 + i));
    mm_write(2, 32'h2);
    idle(1);
    chk("flush_valid", 32'(source_valid), 32'd0);
    mm_read(1, rv); chk("flush_status", rv, 32'h0000_0100);
    mm_read(2, rv); chk("flush_ctrl", rv, 32'd0);

    // Asynchronous reset mid-stream.
    mm_write(2, 32'h1);
    for (int i = 0; i < 6; i++) mm_write(0, 32'(400 + i));
    idle(1);
    chk("pre_reset_valid", 32'(source_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(source_valid), 32'd0);
    chk("async_rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mm_read(1, rv); chk("post_rst_status", rv, 32'h0000_0100);
    mm_read(2, rv); chk("post_rst_ctrl", rv, 32'd0);

    // Underrun counter (or its absence).
    mm_write(3, 32'h0);
    idle(1);
    source_ready = 1'b1;
    idle(10);
    source_ready = 1'b0;
    mm_read(3, rv);
`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
    chk("underrun_10", rv, 32'd10);
    mm_write(3, 32'h0);
    idle(1);
    mm_read(3, rv); chk("underrun_clr", rv, 32'd0);
`else
    chk("underrun_absent", rv, 32'd0);
`endif

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
